// File: rtl/dma_read_engine_if.sv
// rtl/dma_read_engine_if.sv - memory-bank and output-stream signal bundle for dma_read_engine
//
// Purpose: carries the memory-bank arbiter handshake and the output data stream.
// Signals:
//   bank_request  [3:0]             one-hot read request to the bank arbiter
//   bank_grant    [3:0]             arbiter grant vector
//   mem_addr      [ADDR_WIDTH-1:0]  current word address
//   mem_rdata     [DATA_WIDTH-1:0]  read data, valid the cycle after grant
//   out_valid / out_ready / out_data  stream to the processing core
// Modports: master = DMA engine side, slave = memory/arbiter/consumer side.
interface dma_read_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [3:0]            bank_request;
  logic [3:0]            bank_grant;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output bank_request, mem_addr, out_valid, out_data,
    input  bank_grant, mem_rdata, out_ready
  );

  modport slave (
    input  bank_request, mem_addr, out_valid, out_data,
    output bank_grant, mem_rdata, out_ready
  );
endinterface

// File: rtl/dma_read_engine.sv
// rtl/dma_read_engine.sv - single-outstanding banked-memory read DMA with output FIFO
//
// Purpose: reads xfer_len consecutive words starting at src_addr from a 4-bank
// memory (bank = address bits [1:0]), buffers them in a FIFO_DEPTH-entry FIFO
// and streams them out. One read is outstanding at a time.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 launch pulse, accepted only when idle
//   src_addr, xfer_len    first word address and word count, sampled on accepted start
//   busy                  high from accepted start until done
//   done                  one-cycle completion pulse
//   bus (master)          bank request/grant, mem_addr/mem_rdata, out stream
//   stall_cycles [15:0]   only with DMA_STALL_CNT_EN: saturating count of REQ
//                         cycles with the request up and no matching grant
// Optional feature macro: DMA_STALL_CNT_EN
module dma_read_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] xfer_len,
  output logic                  busy,
  output logic                  done,
  dma_read_engine_if.master     bus
`ifdef DMA_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]      DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]      CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] remaining;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  logic       accept;
  logic       req_ok;
  logic [3:0] req_vec;
  logic       grant_hit;
  logic       push;
  logic       pop;

  assign accept = (state == IDLE) && start;
  // Request only while a free FIFO slot is guaranteed for the returning word.
  assign req_ok    = (state == REQ) && (count < DEPTH_CNT);
  assign req_vec   = req_ok ? (4'b0001 << addr_q[1:0]) : 4'b0000;
  assign grant_hit = |(req_vec & bus.bank_grant);
  // The word granted in REQ arrives on mem_rdata during the following DATA cycle.
  assign push      = (state == DATA);
  assign pop       = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (xfer_len == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q    <= src_addr;
              remaining <= xfer_len;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (grant_hit) state <= DATA;
        end
        DATA: begin
          addr_q    <= addr_q + ADDR_ONE;
          remaining <= remaining - ADDR_ONE;
          state     <= (remaining != ADDR_ONE) ? REQ : DRAIN;
        end
        DRAIN: begin
          if (count == '0) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: out_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_rdata;
  end

`ifdef DMA_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (req_ok && !grant_hit && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

  assign bus.bank_request = req_vec;
  assign bus.mem_addr     = addr_q;
  assign bus.out_valid    = (count != '0);
  assign bus.out_data     = fifo_mem[rd_ptr];
  assign busy             = (state != IDLE);
  assign done             = done_q;

endmodule

// File: doc/dma_read_engine.md
DMA_READ_ENGINE -- requirements
Module: dma_read_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, word address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, power of two and at least 2.
REQ-004 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-005 SHALL have ports: reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports: start  input  1  one-cycle transfer launch pulse.
REQ-007 SHALL have ports: src_addr  input  ADDR_WIDTH  first word address, sampled on accepted start.
REQ-008 SHALL have ports: xfer_len  input  ADDR_WIDTH  word count, sampled on accepted start.
REQ-009 SHALL have ports: busy  output  1  high from accepted start until done.
REQ-010 SHALL have ports: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports: bank_request  output  4  one-hot read request to the memory-bank arbiter.
REQ-012 SHALL have ports: bank_grant  input  4  arbiter grant vector.
REQ-013 SHALL have ports: mem_addr  output  ADDR_WIDTH  current word address.
REQ-014 SHALL have ports: mem_rdata  input  DATA_WIDTH  read data, valid the cycle after grant.
REQ-015 SHALL have ports: out_valid / out_ready / out_data  output / input / output  1 / 1 / DATA_WIDTH  stream to processing core.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, DATA, DRAIN.
REQ-017 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-018 SHALL, on start with xfer_len=0, stay in IDLE, keep busy low, pulse done the next cycle.
REQ-019 SHALL, on start with xfer_len>0, load address/remaining counters, go to REQ, raise busy next cycle.
REQ-020 SHALL select bank as mem_addr[1:0]; bank_request is one-hot on that bit only in REQ.
REQ-021 SHALL assert bank_request only when FIFO occupancy < FIFO_DEPTH; otherwise hold in REQ with request low.
REQ-022 SHALL move REQ->DATA when bank_grant bit of the requested bank is high; grants on other bits are ignored.
REQ-023 SHALL in DATA write mem_rdata to FIFO, increment mem_addr (wrap modulo 2^ADDR_WIDTH), decrement remaining.
REQ-024 SHALL move DATA->REQ if remaining after decrement >0, else DATA->DRAIN.
REQ-025 SHALL move DRAIN->IDLE when FIFO empty, pulsing done and dropping busy that same transition cycle+1.
REQ-026 SHALL present FIFO head as out_data with out_valid=!empty; pop when out_valid&&out_ready.
REQ-027 SHALL handle simultaneous push and pop with occupancy unchanged, including when full.
REQ-028 SHALL keep one read outstanding maximum; throughput ceiling is one word per 2 cycles.

Reset
REQ-029 SHALL, on reset_n low, asynchronously force IDLE, FIFO empty, busy=0, done=0, bank_request=0, out_valid=0, mem_addr=0.
REQ-030 SHALL, on reset mid-transfer, discard buffered and in-flight data; no done pulse is produced.
REQ-031 SHALL release reset synchronously to clk and accept start from the first active edge after release.

Configuration
REQ-032 SHALL, with DMA_STALL_CNT_EN defined, add output stall_cycles (16 bits) counting cycles in REQ with request high and no matching grant, saturating at 0xFFFF, cleared on accepted start and on reset.
REQ-033 SHALL, without DMA_STALL_CNT_EN, omit the stall_cycles port and counter entirely.

Verification
REQ-034 SHALL cover: src_addr=0x0010, len=4, grant next cycle, out_ready=1 -> words from 0x10..0x13 in order, bank_request 0001,0010,0100,1000, done once.
REQ-035 SHALL cover: len=0 start -> busy stays 0, done pulses one cycle later, no bank_request.
REQ-036 SHALL cover: len=8, out_ready=0 -> exactly FIFO_DEPTH=4 words fetched, bank_request low afterward; raise out_ready -> remaining 4 delivered, done.
REQ-037 SHALL cover: src_addr=0xFFFE, len=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-038 SHALL cover: grant withheld 5 cycles then given; start pulsed mid-transfer -> one word delivered, second start ignored, stall_cycles=5 with DMA_STALL_CNT_EN.
REQ-039 SHALL cover: reset_n low during DATA of len=6 transfer -> all outputs reset values immediately, no done, new start after release works.
